fmap_stream_reader: RTL and testbench

FMAP_STREAM_READER -- requirements
Module: fmap_stream_reader

---
 rtl/fmap_pkg.sv | 14 +
 rtl/fmap_skid_fifo.sv | 45 ++++
 rtl/fmap_stream_reader.sv | 140 ++++++++++++++
 tb/tb_fmap_stream_reader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fmap_pkg.sv
// Shared defaults and the reader state encoding for the feature-map stream reader.
package fmap_pkg;

    localparam int FMAP_DATA_WIDTH = 8;
    localparam int FMAP_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } reader_state_e;

endpackage

// File: rtl/fmap_skid_fifo.sv
// Two-entry FIFO carrying signed data plus a last flag.
// The head entry stays put until popped, so outputs remain stable under stall.
module fmap_skid_fifo #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic signed [DATA_WIDTH-1:0] push_data,
    input  logic                         push_last,
    input  logic                         pop,
    output logic [1:0]                   count,
    output logic signed [DATA_WIDTH-1:0] head_data,
    output logic                         head_last
);

    logic signed [DATA_WIDTH-1:0] mem_data [2];
    logic [1:0]                   mem_last;
    logic                         wr_ptr;
    logic                         rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_data <= '{default: '0};
            mem_last <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head_data = mem_data[rd_ptr];
    assign head_last = mem_last[rd_ptr];

endmodule

// File: rtl/fmap_stream_reader.sv
// Streams length elements from a 1W3R buffer read port into a valid/ready stream.
// Optional macro FMAP_RD_STRIDE_EN adds a captured i_stride input (default stride 1).
module fmap_stream_reader
    import fmap_pkg::*;
#(
    parameter int DATA_WIDTH = FMAP_DATA_WIDTH,
    parameter int ADDR_WIDTH = FMAP_ADDR_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    input  logic [ADDR_WIDTH-1:0]        i_base_addr,
    input  logic [LEN_WIDTH-1:0]         i_length,
`ifdef FMAP_RD_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0]        i_stride,
`endif
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_rd_en,
    output logic [ADDR_WIDTH-1:0]        o_rd_addr,
    input  logic signed [DATA_WIDTH-1:0] i_rd_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic signed [DATA_WIDTH-1:0] o_data,
    output logic                         o_last
);

    reader_state_e         state;
    reader_state_e         state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] stride;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  rd_cnt;
    logic                  in_flight;
    logic                  in_flight_last;
    logic [1:0]            fifo_count;
    logic                  head_last;
    logic                  accept;
    logic                  pop;
    logic                  last_issue;
    logic [2:0]            occupancy;

    assign accept     = (state == ST_IDLE) && i_start;
    assign last_issue = (rd_cnt == len_q - LEN_WIDTH'(1));
    assign o_valid    = (fifo_count != 2'd0);
    assign pop        = o_valid && i_ready;
    assign o_last     = o_valid && head_last;
    assign o_rd_addr  = addr_q;

    // Slots claimed after this edge: a read issued now lands next cycle, so the
    // beat leaving this cycle frees its slot in time to keep full throughput.
    assign occupancy  = 3'(fifo_count) + 3'(in_flight) - 3'(pop);

`ifdef FMAP_RD_STRIDE_EN
    logic [ADDR_WIDTH-1:0] stride_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stride_q <= '0;
        end else if (accept) begin
            stride_q <= i_stride;
        end
    end

    assign stride = stride_q;
`else
    assign stride = ADDR_WIDTH'(1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (i_start) state_next = (i_length == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (o_rd_en && last_issue) state_next = ST_DRAIN;
            ST_DRAIN: if (pop && o_last) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_rd_en = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state)
            ST_RUN: begin
                o_busy  = 1'b1;
                o_rd_en = (occupancy < 3'd2);
            end
            ST_DRAIN: o_busy = 1'b1;
            ST_DONE:  o_done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q         <= '0;
            len_q          <= '0;
            rd_cnt         <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= i_base_addr;
                len_q  <= i_length;
                rd_cnt <= '0;
            end else if (o_rd_en) begin
                addr_q <= addr_q + stride;
                rd_cnt <= rd_cnt + LEN_WIDTH'(1);
            end
            in_flight      <= o_rd_en;
            in_flight_last <= o_rd_en && last_issue;
        end
    end

    fmap_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_flight),
        .push_data (i_rd_data),
        .push_last (in_flight_last),
        .pop       (pop),
        .count     (fifo_count),
        .head_data (o_data),
        .head_last (head_last)
    );

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Directed self-checking bench for fmap_stream_reader with a behavioural read-port buffer.
module tb_fmap_stream_reader;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int LW = 11;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic [LW-1:0]        length;
`ifdef FMAP_RD_STRIDE_EN
    logic [AW-1:0]        stride;
`endif
    logic                 busy, done, rd_en, valid, ready, last;
    logic [AW-1:0]        rd_addr;
    logic signed [DW-1:0] rd_data;
    logic signed [DW-1:0] data;
    logic signed [DW-1:0] mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    fmap_stream_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_length    (length),
`ifdef FMAP_RD_STRIDE_EN
        .i_stride    (stride),
`endif
        .o_busy      (busy),
        .o_done      (done),
        .o_rd_en     (rd_en),
        .o_rd_addr   (rd_addr),
        .i_rd_data   (rd_data),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_data      (data),
        .o_last      (last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_rd_en"}, {31'd0, rd_en}, 32'd0);
        check({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_last"}, {31'd0, last}, 32'd0);
        check({tag, "_rd_addr"}, {22'd0, rd_addr}, 32'd0);
        check({tag, "_data"}, {24'd0, data}, 32'd0);
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0,1.
    // abort_at > 0: reset after that many beats. poke: i_start while busy.
    task automatic run_xfer(input logic [AW-1:0] b, input logic [LW-1:0] len,
                            input logic [AW-1:0] str, input int mode,
                            input int abort_at, input bit poke);
        int c, nrd, nacc, first_valid, done_c, last_beat_c;
        bit held_v, held_l;
        logic [DW-1:0] held_d;
        logic [AW-1:0] a;
        start = 1'b1;
        base_addr = b;
        length = len;
`ifdef FMAP_RD_STRIDE_EN
        stride = str;
`endif
        step();
        start = 1'b0;
        c = 0; nrd = 0; nacc = 0; first_valid = -1; done_c = -1; last_beat_c = -1;
        held_v = 1'b0; held_l = 1'b0; held_d = '0;
        while (c < 200 && done_c < 0) begin
            ready = (mode == 1) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            start = poke && (c == 2);
            if (poke) base_addr = b ^ 10'h155;
            #1;
            if (c == 0) check("busy_after_start", {31'd0, busy}, {31'd0, (len != 0)});
            if (held_v) begin
                check("stall_valid", {31'd0, valid}, 32'd1);
                check("stall_data", {24'd0, data}, {24'd0, held_d});
                check("stall_last", {31'd0, last}, {31'd0, held_l});
            end
            if (rd_en) begin
                a = b + AW'(nrd) * str;
                check("rd_addr", {22'd0, rd_addr}, {22'd0, a});
                nrd++;
            end
            if (valid && first_valid < 0) first_valid = c;
            if (valid && ready) begin
                a = b + AW'(nacc) * str;
                check("beat_data", {24'd0, data}, {24'd0, mem[a]});
                check("beat_last", {31'd0, last}, {31'd0, (nacc == int'(len) - 1)});
                nacc++;
                last_beat_c = c;
            end
            held_v = valid && !ready;
            held_d = data;
            held_l = last;
            check("outstanding_le2", {31'd0, (nrd - nacc <= 2)}, 32'd1);
            if (done) begin
                done_c = c;
                check("busy_low_in_done", {31'd0, busy}, 32'd0);
            end
            if (abort_at > 0 && nacc == abort_at) begin
                #1 rst_n = 1'b0;
                #1 check_all_zero("abort");
                for (int i = 0; i < 3; i++) begin
                    step();
                    check("abort_no_done", {31'd0, done}, 32'd0);
                    check("abort_no_valid", {31'd0, valid}, 32'd0);
                end
                @(negedge clk) rst_n = 1'b1;
                step();
                return;
            end
            if (done_c < 0) begin
                step();
                c++;
            end
        end
        check("done_seen", {31'd0, (done_c >= 0)}, 32'd1);
        check("reads_issued", nrd, {21'd0, len});
        check("beats_accepted", nacc, {21'd0, len});
        if (len == 0) begin
            check("len0_done_cycle", done_c, 32'd0);
            check("len0_no_valid", first_valid, 32'hFFFF_FFFF);
        end else begin
            check("done_after_last", done_c, last_beat_c + 1);
            if (mode == 0) begin
                check("first_valid_cycle", first_valid, 32'd2);
                check("throughput", done_c, 32'(len) + 32'd2);
            end
        end
        step();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_not_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        start = 1'b0;
        ready = 1'b1;
        base_addr = '0;
        length = '0;
`ifdef FMAP_RD_STRIDE_EN
        stride = '0;
`endif
        rd_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i * 37 + 11);
        mem[16] = 8'sd5;
        mem[17] = -8'sd3;
        mem[18] = 8'sd7;
        mem[19] = -8'sd128;

        #2 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        step();

        run_xfer(10'h010, 11'd4, 10'd1, 0, 0, 1'b0);
        run_xfer(10'h3FE, 11'd4, 10'd1, 0, 0, 1'b0);
        run_xfer(10'h100, 11'd8, 10'd1, 1, 0, 1'b0);
        run_xfer(10'h050, 11'd0, 10'd1, 0, 0, 1'b0);
        run_xfer(10'h200, 11'd10, 10'd1, 0, 3, 1'b0);
        check_all_zero("post_abort");
        run_xfer(10'h020, 11'd2, 10'd1, 0, 0, 1'b0);
`ifdef FMAP_RD_STRIDE_EN
        run_xfer(10'h000, 11'd3, 10'd3, 0, 0, 1'b1);
`else
        run_xfer(10'h030, 11'd6, 10'd1, 0, 0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
